// File: rtl/ternary_unpack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ternary_unpack_fifo
// Purpose  : Word FIFO between the DDR read path and the ternary MAC operand
//            feed. Each stored DataWidth-bit word is handed out as
//            GroupsPerWord consecutive groups of Lanes ternary cells, lowest
//            cells first. The word is retired when its last group is popped.
//            Supports flush and a fill-level readout.
// Ports    : clk_i        rising-edge clock
//            rst_i        synchronous active-high reset
//            flush_i      discard all contents (priority below rst_i)
//            in_data_i    pushed word
//            in_valid_i   push request
//            in_ready_o   space available (registered state only)
//            out_data_o   current cell group, lane k at [k*CellWidth +: CellWidth]
//            out_valid_o  group available
//            out_ready_i  consumer pop
//            out_last_o   current group is the final group of its word
//            err_o        [0] sticky overflow, [1] sticky underflow
//                         (present only with TERNARY_UNPACK_FIFO_ERR_EN)
//            level_o      words held, including a partially consumed head
// Options  : `define TERNARY_UNPACK_FIFO_ERR_EN adds err_o and its logic.
// Revision : 1.0 - initial release
// ============================================================================
module ternary_unpack_fifo #(
  parameter int DataWidth = 512,
  parameter int CellWidth = 2,
  parameter int Lanes     = 8,
  parameter int Depth     = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic [DataWidth-1:0]         in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  output logic [Lanes*CellWidth-1:0]   out_data_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic                         out_last_o,
`ifdef TERNARY_UNPACK_FIFO_ERR_EN
  output logic [1:0]                   err_o,
`endif
  output logic [$clog2(Depth):0]       level_o
);

  localparam int CellsPerWord  = DataWidth / CellWidth;
  localparam int GroupsPerWord = CellsPerWord / Lanes;
  localparam int GroupW        = Lanes * CellWidth;
  localparam int PtrW          = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int LvlW          = PtrW + 1;
  localparam int GrpW          = (GroupsPerWord > 1) ? $clog2(GroupsPerWord) : 1;

  localparam logic [GrpW-1:0] c_grp_last   = GrpW'(GroupsPerWord - 1);
  localparam logic [LvlW-1:0] c_level_full = LvlW'(Depth);
  localparam logic [LvlW-1:0] c_level_one  = LvlW'(1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  generate
    if ((CellsPerWord % Lanes) != 0 || (DataWidth % CellWidth) != 0) begin : g_bad_lanes
      $error("ternary_unpack_fifo: DataWidth/CellWidth must be a multiple of Lanes");
    end
    if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
      $error("ternary_unpack_fifo: Depth must be a power of two and at least 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DataWidth-1:0] r_mem [Depth];
  logic [PtrW-1:0]      r_head;
  logic [PtrW-1:0]      r_tail;
  logic [GrpW-1:0]      r_grp;
  logic [LvlW-1:0]      r_level;

  logic                 w_in_ready;
  logic                 w_out_valid;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_retire;
  logic                 w_grp_last;
  logic [DataWidth-1:0] w_head_word;
  logic [GroupW-1:0]    w_groups [GroupsPerWord];

  // Handshake flags derive from the registered level only, so in_ready_o
  // carries no combinational path from out_ready_i.
  assign w_in_ready  = (r_level != c_level_full);
  assign w_out_valid = (r_level != '0);
  assign w_grp_last  = (r_grp == c_grp_last);

  assign w_push   = in_valid_i  && w_in_ready;
  assign w_pop    = out_ready_i && w_out_valid;
  assign w_retire = w_pop && w_grp_last;

  // --------------------------------------------------------------------------
  // Group selection: slice the head word into groups, pick the current one.
  // --------------------------------------------------------------------------
  assign w_head_word = r_mem[r_head];

  generate
    for (genvar g = 0; g < GroupsPerWord; g++) begin : g_group
      assign w_groups[g] = w_head_word[g*GroupW +: GroupW];
    end
  endgenerate

  // Driven to zero when empty so stale or uninitialised entries never leak.
  assign out_data_o  = w_out_valid ? w_groups[r_grp] : '0;
  assign out_valid_o = w_out_valid;
  assign out_last_o  = w_out_valid && w_grp_last;
  assign in_ready_o  = w_in_ready;
  assign level_o     = r_level;

  // --------------------------------------------------------------------------
  // Data array: no reset. Writes are suppressed during reset/flush so a push
  // in those cycles has no effect at all.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i && !flush_i) begin
      r_mem[r_tail] <= in_data_i;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, group index and level
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_grp   <= '0;
      r_level <= '0;
    end else begin
      // Depth is a power of two, so pointer wrap is the natural rollover.
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        if (w_grp_last) begin
          r_grp  <= '0;
          r_head <= r_head + 1'b1;
        end else begin
          r_grp  <= r_grp + 1'b1;
        end
      end
      // Level counts words, so only retiring the last group decrements it.
      unique case ({w_push, w_retire})
        2'b10:   r_level <= r_level + c_level_one;
        2'b01:   r_level <= r_level - c_level_one;
        default: r_level <= r_level;
      endcase
    end
  end

`ifdef TERNARY_UNPACK_FIFO_ERR_EN
  // --------------------------------------------------------------------------
  // Sticky error flags: [0] push attempted while full, [1] pop while empty.
  // --------------------------------------------------------------------------
  logic [1:0] r_err;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_err <= 2'b00;
    end else begin
      r_err[0] <= r_err[0] | (in_valid_i  && !w_in_ready);
      r_err[1] <= r_err[1] | (out_ready_i && !w_out_valid);
    end
  end

  assign err_o = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ternary_unpack_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ternary_unpack_fifo
// Purpose  : Directed self-checking bench for ternary_unpack_fifo with the
//            default parameters (512-bit words, 8 lanes of 2-bit cells,
//            32 groups per word, depth 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ternary_unpack_fifo;

  localparam int DW = 512;
  localparam int GW = 16;
  localparam int NG = 32;

  logic          clk;
  logic          rst_i;
  logic          flush_i;
  logic [DW-1:0] in_data_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [GW-1:0] out_data_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          out_last_o;
  logic [2:0]    level_o;
`ifdef TERNARY_UNPACK_FIFO_ERR_EN
  logic [1:0]    err_o;
`endif

  int checks   = 0;
  int failures = 0;

  ternary_unpack_fifo dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_last_o  (out_last_o),
`ifdef TERNARY_UNPACK_FIFO_ERR_EN
    .err_o       (err_o),
`endif
    .level_o     (level_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled there.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rand_word(output logic [DW-1:0] w);
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
  endtask

  // Pops the given word from group start_g through group 31, checking each.
  task automatic drain_word(input string tag, input logic [DW-1:0] w, input int start_g);
    out_ready_i = 1'b1;
    for (int g = start_g; g < NG; g++) begin
      check({tag, "_data"}, 64'(out_data_o), 64'(w[g*GW +: GW]));
      check({tag, "_last"}, 64'(out_last_o), 64'(g == NG-1));
      step();
    end
    out_ready_i = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] w);
    in_data_i  = w;
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
  endtask

  logic [DW-1:0] w0, wa, wb, wc, wd, we, w5;

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_data_i = '0; in_valid_i = 1'b0; out_ready_i = 1'b0;

    // Word with cell i = i mod 3 encoded 00 / 01 / 11
    for (int i = 0; i < DW/2; i++) begin
      case (i % 3)
        0:       w0[i*2 +: 2] = 2'b00;
        1:       w0[i*2 +: 2] = 2'b01;
        default: w0[i*2 +: 2] = 2'b11;
      endcase
    end

    step(); step();
    rst_i = 1'b0;
    step();

    // Reset state
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_ready", 64'(in_ready_o),  64'd1);
    check("rst_level", 64'(level_o),     64'd0);
    check("rst_last",  64'(out_last_o),  64'd0);
    check("rst_data",  64'(out_data_o),  64'd0);

    // Single push, 1-cycle latency, first group hand computed
    push(w0);
    check("p1_valid", 64'(out_valid_o), 64'd1);
    check("p1_level", 64'(level_o),     64'd1);
    check("p1_data",  64'(out_data_o),  64'h4D34);
    check("p1_last",  64'(out_last_o),  64'd0);

    // Drain 32 groups back to back
    out_ready_i = 1'b1;
    for (int g = 0; g < NG; g++) begin
      check("dr_level", 64'(level_o),    64'd1);
      check("dr_data",  64'(out_data_o), 64'(w0[g*GW +: GW]));
      check("dr_last",  64'(out_last_o), 64'(g == NG-1));
      step();
    end
    out_ready_i = 1'b0;
    check("dr_end_level", 64'(level_o),     64'd0);
    check("dr_end_valid", 64'(out_valid_o), 64'd0);

    // Fill to depth, overflow attempt dropped, drain all 128 groups
    rand_word(wa); rand_word(wb); rand_word(wc); rand_word(wd); rand_word(w5);
    push(w0); push(wa); push(wb); push(wc);
    check("full_level", 64'(level_o),    64'd4);
    check("full_ready", 64'(in_ready_o), 64'd0);
    push(w5);
    check("ovf_level", 64'(level_o), 64'd4);
`ifdef TERNARY_UNPACK_FIFO_ERR_EN
    check("ovf_err0", 64'(err_o[0]), 64'd1);
`endif
    drain_word("fw0", w0, 0);
    drain_word("fwa", wa, 0);
    drain_word("fwb", wb, 0);
    drain_word("fwc", wc, 0);
    check("fdr_level", 64'(level_o),     64'd0);
    check("fdr_valid", 64'(out_valid_o), 64'd0);

    // Full with head at group 31: simultaneous push is refused, pop retires
    push(wa); push(wb); push(wc); push(wd);
    out_ready_i = 1'b1;
    for (int g = 0; g < NG-1; g++) step();
    check("h31_last",  64'(out_last_o), 64'd1);
    check("h31_level", 64'(level_o),    64'd4);
    in_data_i  = w5;
    in_valid_i = 1'b1;
    step();
    check("h31_level_after", 64'(level_o),    64'd3);
    check("h31_ready_after", 64'(in_ready_o), 64'd1);
    check("h31_head_data",   64'(out_data_o), 64'(wb[0 +: GW]));
    // Push and mid-word pop together
    step();
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    check("mid_level", 64'(level_o),    64'd4);
    check("mid_data",  64'(out_data_o), 64'(wb[GW +: GW]));
    drain_word("hwb", wb, 1);
    drain_word("hwc", wc, 0);
    drain_word("hwd", wd, 0);
    drain_word("hw5", w5, 0);
    check("h_end_level", 64'(level_o), 64'd0);

    // Flush at level 2, head at group 5, with push and pop in same cycle
    push(wa); push(wb);
    out_ready_i = 1'b1;
    for (int g = 0; g < 5; g++) step();
    check("pre_flush_data", 64'(out_data_o), 64'(wa[5*GW +: GW]));
    flush_i    = 1'b1;
    in_data_i  = wc;
    in_valid_i = 1'b1;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    check("fl_level", 64'(level_o),     64'd0);
    check("fl_valid", 64'(out_valid_o), 64'd0);
    check("fl_ready", 64'(in_ready_o),  64'd1);
`ifdef TERNARY_UNPACK_FIFO_ERR_EN
    check("fl_err", 64'(err_o), 64'd0);
`endif
    rand_word(we);
    push(we);
    check("pf_data",  64'(out_data_o), 64'(we[0 +: GW]));
    check("pf_level", 64'(level_o),    64'd1);
    check("pf_last",  64'(out_last_o), 64'd0);

    // Reset mid-drain at level 3
    push(wa); push(wb);
    out_ready_i = 1'b1;
    step(); step();
    check("pre_rst_level", 64'(level_o), 64'd3);
    rst_i      = 1'b1;
    in_data_i  = wc;
    in_valid_i = 1'b1;
    step();
    rst_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    check("mr_valid", 64'(out_valid_o), 64'd0);
    check("mr_ready", 64'(in_ready_o),  64'd1);
    check("mr_level", 64'(level_o),     64'd0);
    check("mr_last",  64'(out_last_o),  64'd0);
    check("mr_data",  64'(out_data_o),  64'd0);

    // Pop while empty is ignored
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    check("uf_level", 64'(level_o),     64'd0);
    check("uf_valid", 64'(out_valid_o), 64'd0);
`ifdef TERNARY_UNPACK_FIFO_ERR_EN
    check("uf_err1", 64'(err_o), 64'd2);
    step();
    check("uf_err1_sticky", 64'(err_o), 64'd2);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check("uf_err_cleared", 64'(err_o), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ternary_unpack_fifo.md
Name: ternary_unpack_fifo

Overview:
- Buffers wide DDR read words and unpacks them into groups of ternary cells for the ternary matmul datapath.
- Generalises the single-cell matrix FIFO: parametrised word width, cell width, depth and output lanes (cells per pop).
- Adds flush, fill level and optional sticky error flags.
- Sits between the DDR read path (write side) and the MAC array operand feed (read side).

Parameters:
- DataWidth, 512, bits per pushed word.
- CellWidth, 2, bits per ternary cell.
- Lanes, 8, cells delivered per pop. CellsPerWord = DataWidth/CellWidth must be a multiple of Lanes; elaboration $error otherwise.
- Depth, 4, word entries; power of two, at least 2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  discard all contents.
- in_data_i  in  DataWidth  pushed word.
- in_valid_i  in  1  push request.
- in_ready_o  out  1  space available.
- out_data_o  out  Lanes*CellWidth  current cell group; lane k in bits [k*CellWidth +: CellWidth].
- out_valid_o  out  1  group available.
- out_ready_i  in  1  consumer pop.
- out_last_o  out  1  group is the final group of its word.
- level_o  out  $clog2(Depth)+1  words held, including the partially consumed head word.

Behaviour:
- Reset (rst_i high at posedge):
  - Pointers, group index and level clear to 0.
  - Outputs after reset: out_valid_o=0, in_ready_o=1, level_o=0, out_last_o=0.
  - Reset mid-stream discards contents; in-flight handshakes that cycle are ignored.
- Storage is Depth×DataWidth registers. No reset on the data array.
- Word 0 of each entry is the lowest bits. Group g of a word covers cells g*Lanes .. g*Lanes+Lanes-1.
- Push handshake: a push occurs when in_valid_i && in_ready_o at posedge.
  - in_ready_o = (level != Depth). It depends only on registered state, with no combinational path from out_ready_i.
  - A push while full is dropped, with no state change.
- Pop handshake: a pop occurs when out_valid_o && out_ready_i.
  - out_valid_o = (level != 0).
  - out_data_o is a combinational read of entry head, group grp; X-free only when valid, driven to 0 otherwise.
- Group index grp counts 0..GroupsPerWord-1 (GroupsPerWord = CellsPerWord/Lanes).
  - On a pop with grp == GroupsPerWord-1: grp goes to 0, head advances with wrap at Depth, and the word is retired.
  - Otherwise grp increments.
- out_last_o = out_valid_o && (grp == GroupsPerWord-1).
- level_next = level + push - retire. A simultaneous push and retire leaves level unchanged.
- Tail wraps Depth-1→0. Latency push→out_valid_o is 1 cycle: a word written at edge N is visible after edge N.
- Full and a same-cycle pop that retires the head: the push is still refused, because in_ready_o was 0 that cycle.
- Empty and pop asserted: ignored.
- flush_i at posedge:
  - Head, tail, grp and level go to 0; a push or pop in the same cycle is ignored.
  - flush has priority below rst_i.
- Ternary encoding passes through unchanged; the block does not check cell legality.

Optional Feature:
- Macro TERNARY_UNPACK_FIFO_ERR_EN.
- When defined: extra output err_o [1:0].
  - Bit0 is sticky overflow, set when in_valid_i && !in_ready_o.
  - Bit1 is sticky underflow, set when out_ready_i && !out_valid_o.
  - Cleared by rst_i or flush_i only.
- When undefined: the port is absent and there is no error logic; datapath behaviour is identical.

Test Plan:
- Reset, then idle → out_valid_o=0, in_ready_o=1, level_o=0. Push word W0 with cell i = i mod 3 (enc 00/01/11) → next cycle out_valid_o=1, level_o=1, lanes 0..7 = 0,+1,-1,0,+1,-1,0,+1.
- Defaults (32 groups/word), push W0: hold out_ready_i high 32 cycles → groups in order; out_last_o only on group 31; level_o 1→0 after 32nd pop; out_valid_o=0 next cycle.
- Push 4 words with no pops → level_o=4, in_ready_o=0. Push a 5th with in_valid_i=1 → dropped; drain 128 groups → data equals W0..W3, tail and head wrap verified. With ERR_EN, err_o[0]=1.
- Full FIFO with head at group 31: assert push and pop in the same cycle → pop retires, push refused, level_o=3. Next cycle, push and a mid-word pop → level_o=4.
- Level 2, head at group 5: assert flush_i together with in_valid_i and out_ready_i → next cycle level_o=0, out_valid_o=0. The next push is read from group 0.
- Mid-drain (level 3), assert rst_i for 1 cycle → all outputs at reset values. Pop with empty FIFO → no change; with ERR_EN, err_o[1]=1 until flush.
